// File: rtl/pwm_pkg.sv
// Shared constants and state encoding for the PWM duty sequencer.
// FAULT only exists when PWM_FAULT_EN is defined.
package pwm_pkg;

  localparam int DEFAULT_DUTY_W   = 8;
  localparam int DEFAULT_TICK_DIV = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    APPLY = 2'd1,
    RAMP  = 2'd2
`ifdef PWM_FAULT_EN
    ,
    FAULT = 2'd3
`endif
  } pwm_state_t;

endpackage

// File: rtl/pwm_duty_sequencer_if.sv
// Command/status bundle between a controller (master) and the duty sequencer (slave).
interface pwm_duty_sequencer_if
  import pwm_pkg::*;
#(
  parameter int DUTY_W = DEFAULT_DUTY_W
);

  logic              cmd_valid;
  logic              cmd_ready;
  logic [DUTY_W-1:0] cmd_duty;
  logic              cmd_ramp;
  logic [DUTY_W-1:0] duty_out;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_duty, cmd_ramp,
    input  cmd_ready, duty_out, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_duty, cmd_ramp,
    output cmd_ready, duty_out, busy, done
  );

endinterface

// File: rtl/pwm_tick_gen.sv
// Free-running period counter; tick marks the last cycle of each PWM period.
module pwm_tick_gen
  import pwm_pkg::*;
#(
  parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CW-1:0] count;

  assign tick = (count == CW'(TICK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/pwm_duty_sequencer.sv
// Steps a registered PWM duty toward a commanded target, only on period boundaries.
// Optional fault shutdown (fault_in/fault_clr/fault ports, FAULT state) under `ifdef PWM_FAULT_EN.
module pwm_duty_sequencer
  import pwm_pkg::*;
#(
  parameter int DUTY_W   = DEFAULT_DUTY_W,
  parameter int TICK_DIV = DEFAULT_TICK_DIV,
  parameter int STEP     = 1
) (
  input  logic clk,
  input  logic rst,
`ifdef PWM_FAULT_EN
  input  logic fault_in,
  input  logic fault_clr,
  output logic fault,
`endif
  pwm_duty_sequencer_if.slave cmd
);

  pwm_state_t        state;
  logic [DUTY_W-1:0] duty_q;
  logic [DUTY_W-1:0] target_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              tick;
  logic              accept;
  logic [DUTY_W-1:0] eff_target;
  logic              eff_ramp;
  logic [DUTY_W:0]   step_ext;
  logic [DUTY_W:0]   up_sum;
  logic [DUTY_W:0]   dn_diff;
  logic [DUTY_W-1:0] ramp_val;
  logic [DUTY_W-1:0] step_next;
`ifdef PWM_FAULT_EN
  logic              fault_q;

  assign fault = fault_q;
`endif

  pwm_tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign cmd.cmd_ready = ready_q;
  assign cmd.duty_out  = duty_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;

  assign accept = cmd.cmd_valid && ready_q && (state == IDLE);

  // A command accepted on a tick cycle takes its first step on that same edge,
  // so the step is computed against the incoming command rather than target_q.
  always_comb begin
    eff_target = accept ? cmd.cmd_duty : target_q;
    eff_ramp   = accept ? cmd.cmd_ramp : (state == RAMP);
    step_ext   = (DUTY_W + 1)'(STEP);
    up_sum     = {1'b0, duty_q} + step_ext;
    dn_diff    = {1'b0, duty_q} - step_ext;
    ramp_val   = eff_target;
    if (eff_target > duty_q) begin
      if (up_sum < {1'b0, eff_target}) begin
        ramp_val = up_sum[DUTY_W-1:0];
      end
    end else if (eff_target < duty_q) begin
      if (!dn_diff[DUTY_W] && (dn_diff[DUTY_W-1:0] > eff_target)) begin
        ramp_val = dn_diff[DUTY_W-1:0];
      end
    end
    step_next = eff_ramp ? ramp_val : eff_target;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      duty_q   <= '0;
      target_q <= '0;
      ready_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef PWM_FAULT_EN
      fault_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef PWM_FAULT_EN
      if (fault_in) begin
        state   <= FAULT;
        duty_q  <= '0;
        ready_q <= 1'b0;
        busy_q  <= 1'b0;
        fault_q <= 1'b1;
      end else
`endif
      begin
        case (state)
          IDLE: begin
            ready_q <= 1'b1;
            if (accept) begin
              target_q <= cmd.cmd_duty;
              if (tick) begin
                duty_q <= step_next;
              end
              if (tick && (step_next == cmd.cmd_duty)) begin
                done_q <= 1'b1;
              end else begin
                state   <= cmd.cmd_ramp ? RAMP : APPLY;
                ready_q <= 1'b0;
                busy_q  <= 1'b1;
              end
            end
          end
          APPLY, RAMP: begin
            if (tick) begin
              duty_q <= step_next;
              if (step_next == target_q) begin
                done_q  <= 1'b1;
                state   <= IDLE;
                ready_q <= 1'b1;
                busy_q  <= 1'b0;
              end
            end
          end
`ifdef PWM_FAULT_EN
          FAULT: begin
            if (fault_clr) begin
              state   <= IDLE;
              ready_q <= 1'b1;
              fault_q <= 1'b0;
            end
          end
`endif
          default: begin
            state   <= IDLE;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_duty_sequencer.sv
// Directed bench for pwm_duty_sequencer: three instances (STEP 1, 2, 4) with a short PWM period.
module tb_pwm_duty_sequencer;
  import pwm_pkg::*;

  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_duty  = 8'd0;
  logic       cmd_ramp  = 1'b0;
  int         sel       = 0;

  pwm_duty_sequencer_if #(.DUTY_W(8)) ifa ();
  pwm_duty_sequencer_if #(.DUTY_W(8)) ifb ();
  pwm_duty_sequencer_if #(.DUTY_W(8)) ifc ();

  assign ifa.cmd_valid = cmd_valid && (sel == 0);
  assign ifb.cmd_valid = cmd_valid && (sel == 1);
  assign ifc.cmd_valid = cmd_valid && (sel == 2);
  assign ifa.cmd_duty  = cmd_duty;
  assign ifb.cmd_duty  = cmd_duty;
  assign ifc.cmd_duty  = cmd_duty;
  assign ifa.cmd_ramp  = cmd_ramp;
  assign ifb.cmd_ramp  = cmd_ramp;
  assign ifc.cmd_ramp  = cmd_ramp;

`ifdef PWM_FAULT_EN
  logic fault_in  = 1'b0;
  logic fault_clr = 1'b0;
  logic fault_a, fault_b, fault_c;
`endif

  pwm_duty_sequencer #(.DUTY_W(8), .TICK_DIV(TD), .STEP(1)) dut_a (
    .clk(clk), .rst(rst),
`ifdef PWM_FAULT_EN
    .fault_in(fault_in), .fault_clr(fault_clr), .fault(fault_a),
`endif
    .cmd(ifa)
  );
  pwm_duty_sequencer #(.DUTY_W(8), .TICK_DIV(TD), .STEP(2)) dut_b (
    .clk(clk), .rst(rst),
`ifdef PWM_FAULT_EN
    .fault_in(1'b0), .fault_clr(1'b0), .fault(fault_b),
`endif
    .cmd(ifb)
  );
  pwm_duty_sequencer #(.DUTY_W(8), .TICK_DIV(TD), .STEP(4)) dut_c (
    .clk(clk), .rst(rst),
`ifdef PWM_FAULT_EN
    .fault_in(1'b0), .fault_clr(1'b0), .fault(fault_c),
`endif
    .cmd(ifc)
  );

  logic [7:0] obs_duty;
  logic       obs_ready, obs_busy, obs_done;

  always_comb begin
    case (sel)
      1:       {obs_duty, obs_ready, obs_busy, obs_done} = {ifb.duty_out, ifb.cmd_ready, ifb.busy, ifb.done};
      2:       {obs_duty, obs_ready, obs_busy, obs_done} = {ifc.duty_out, ifc.cmd_ready, ifc.busy, ifc.done};
      default: {obs_duty, obs_ready, obs_busy, obs_done} = {ifa.duty_out, ifa.cmd_ready, ifa.busy, ifa.done};
    endcase
  end

  // Period position as the bench expects it; a duty change must land when this reads 0.
  int tb_count;
  always @(posedge clk or posedge rst) begin
    if (rst) tb_count <= 0;
    else     tb_count <= (tb_count == TD - 1) ? 0 : tb_count + 1;
  end

  int         pass_count  = 0;
  int         check_count = 0;
  logic [7:0] seen[$];
  int         exp_q[$];
  int         done_count;
  int         off_tick;
  int         duty_at_done;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    check_count++;
    if (observed == expected) pass_count++;
    else $display("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
  endtask

  task automatic resetDut();
    cmd_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Presents one command away from a tick edge; with hold, valid stays up with a different duty.
  task automatic applyStimulus(input logic [7:0] duty, input logic ramp, input logic hold);
    @(negedge clk);
    if (tb_count == TD - 1) @(negedge clk);
    cmd_duty  = duty;
    cmd_ramp  = ramp;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) cmd_duty = 8'd200;
    else      cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic runUntilDone(input int budget, input int tail);
    logic [7:0] prev;
    int stop_at;
    seen.delete();
    done_count   = 0;
    off_tick     = 0;
    duty_at_done = -1;
    stop_at      = -1;
    prev         = obs_duty;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (obs_duty != prev) begin
        seen.push_back(obs_duty);
        if (tb_count != 0) off_tick++;
        prev = obs_duty;
      end
      if (obs_done) begin
        done_count++;
        duty_at_done = obs_duty;
        cmd_valid = 1'b0;
        if (stop_at < 0) stop_at = i + tail;
      end
      if (i == stop_at) break;
    end
  endtask

  task automatic checkSeq(input string tag, input int final_duty);
    checkOutput({tag, "_len"}, seen.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
      checkOutput($sformatf("%s_step%0d", tag, i), int'(seen[i]), exp_q[i]);
    checkOutput({tag, "_done_count"}, done_count, 1);
    checkOutput({tag, "_duty_at_done"}, duty_at_done, final_duty);
    checkOutput({tag, "_on_tick"}, off_tick, 0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int reached;

    sel = 0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_duty", obs_duty, 0);
    checkOutput("rst_ready", obs_ready, 0);
    checkOutput("rst_busy", obs_busy, 0);
    checkOutput("rst_done", obs_done, 0);
    rst = 1'b0;
    #1;
    checkOutput("ready_before_clk", obs_ready, 0);
    @(negedge clk);
    checkOutput("ready_after_clk", obs_ready, 1);

    applyStimulus(8'd128, 1'b0, 1'b0);
    checkOutput("jump_busy", obs_busy, 1);
    checkOutput("jump_ready_low", obs_ready, 0);
    runUntilDone(4 * TD, TD);
    exp_q = '{128};
    checkSeq("jump128", 128);
    checkOutput("jump_ready_back", obs_ready, 1);
    checkOutput("jump_busy_clear", obs_busy, 0);

    resetDut();
    sel = 1;
    applyStimulus(8'd5, 1'b1, 1'b0);
    checkOutput("ramp5_busy", obs_busy, 1);
    runUntilDone(8 * TD, TD);
    exp_q = '{2, 4, 5};
    checkSeq("ramp5", 5);

    resetDut();
    sel = 2;
    applyStimulus(8'd250, 1'b0, 1'b0);
    runUntilDone(4 * TD, 2);
    exp_q = '{250};
    checkSeq("to250", 250);
    applyStimulus(8'd255, 1'b1, 1'b0);
    runUntilDone(6 * TD, TD);
    exp_q = '{254, 255};
    checkSeq("ramp255", 255);
    checkOutput("ramp255_hold", obs_duty, 255);

    resetDut();
    sel = 0;
    applyStimulus(8'd10, 1'b1, 1'b1);
    checkOutput("hold_ready_low", obs_ready, 0);
    runUntilDone(20 * TD, TD);
    exp_q.delete();
    for (int v = 1; v <= 10; v++) exp_q.push_back(v);
    checkSeq("hold", 10);
    checkOutput("hold_ready_back", obs_ready, 1);
    checkOutput("hold_busy_clear", obs_busy, 0);

    resetDut();
    sel = 0;
    applyStimulus(8'd100, 1'b1, 1'b0);
    reached = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (obs_duty == 8'd60) begin
        reached = 1;
        break;
      end
    end
    checkOutput("mid_reached60", reached, 1);
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_duty", obs_duty, 0);
    checkOutput("mid_rst_busy", obs_busy, 0);
    checkOutput("mid_rst_done", obs_done, 0);
    checkOutput("mid_rst_ready", obs_ready, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    runUntilDone(3 * TD, 0);
    checkOutput("mid_after_done", done_count, 0);
    checkOutput("mid_after_changes", seen.size(), 0);

`ifdef PWM_FAULT_EN
    resetDut();
    sel = 0;
    applyStimulus(8'd100, 1'b1, 1'b0);
    reached = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (obs_duty == 8'd20) begin
        reached = 1;
        break;
      end
    end
    checkOutput("flt_reached20", reached, 1);
    fault_in = 1'b1;
    @(negedge clk);
    checkOutput("flt_duty", obs_duty, 0);
    checkOutput("flt_flag", fault_a, 1);
    checkOutput("flt_ready", obs_ready, 0);
    checkOutput("flt_busy", obs_busy, 0);
    checkOutput("flt_done", obs_done, 0);
    fault_in = 1'b0;
    @(negedge clk);
    checkOutput("flt_sticky", fault_a, 1);
    fault_clr = 1'b1;
    @(negedge clk);
    fault_clr = 1'b0;
    checkOutput("flt_cleared", fault_a, 0);
    checkOutput("flt_ready_back", obs_ready, 1);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule

// File: doc/pwm_duty_sequencer.md
PWM_DUTY_SEQUENCER -- requirements
Module: pwm_duty_sequencer

Interface
REQ-001 SHALL have parameter DUTY_W, default 8: width of duty setpoint and duty output.
REQ-002 SHALL have parameter TICK_DIV, default 256: clk cycles per duty-update tick, equal to one PWM period.
REQ-003 SHALL have parameter STEP, default 1: duty change per tick while ramping, range 1..2^DUTY_W-1.
REQ-004 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-005 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-006 SHALL have port cmd_valid, input, 1: command present.
REQ-007 SHALL have port cmd_ready, output, 1: sequencer can accept a command.
REQ-008 SHALL have port cmd_duty, input, DUTY_W: target duty, 0 = off, 2^DUTY_W-1 = max.
REQ-009 SHALL have port cmd_ramp, input, 1: 1 = ramp by STEP per tick, 0 = jump at next tick.
REQ-010 SHALL have port duty_out, output, DUTY_W: registered duty that drives the PWM generator duty input.
REQ-011 SHALL have port busy, output, 1: a command is in progress.
REQ-012 SHALL have port done, output, 1: single-cycle pulse when duty_out reaches the target.

Function
REQ-013 SHALL run a free-running tick counter 0..TICK_DIV-1 that wraps to 0; tick is high in the cycle where count == TICK_DIV-1.
REQ-014 SHALL change duty_out only on the clock edge where tick is high, so every change lands on a PWM period boundary.
REQ-015 SHALL implement states IDLE, APPLY and RAMP, plus FAULT when PWM_FAULT_EN is defined.
REQ-016 SHALL drive cmd_ready = 1 only in IDLE; busy = 1 in APPLY and RAMP.
REQ-017 SHALL accept a command on cmd_valid && cmd_ready, latch cmd_duty into target, and go to APPLY if cmd_ramp = 0, else RAMP.
REQ-018 SHALL, in APPLY on tick, set duty_out = target, pulse done and return to IDLE.
REQ-019 SHALL, in RAMP on each tick, move duty_out toward target by STEP; if |target - duty_out| <= STEP, set duty_out = target instead.
REQ-020 SHALL pulse done and return to IDLE on the same edge that ramping makes duty_out equal target.
REQ-021 SHALL compute ramp arithmetic in DUTY_W+1 bits so duty_out never wraps or overshoots (no 255→0 or 0→255).
REQ-022 SHALL handle target == duty_out at acceptance by completing at the next tick, with done pulsed and no change to duty_out.
REQ-023 SHALL leave the tick counter unaffected by command acceptance; the first update occurs at the next tick, which may be in the acceptance cycle itself.
REQ-024 SHALL ignore cmd_valid while not in IDLE, with no queuing.

Reset
REQ-025 SHALL, on rst = 1, immediately force state IDLE, tick count 0, duty_out 0, target 0, busy 0, done 0, fault 0.
REQ-026 SHALL hold cmd_ready at 0 while rst is asserted, and drive it to 1 from the first clock after deassertion.
REQ-027 SHALL abandon any in-progress ramp when reset is asserted mid-operation, with no done pulse.

Configuration
REQ-028 SHALL, with PWM_FAULT_EN defined, add port fault_in (input, 1), port fault_clr (input, 1) and port fault (output, 1).
REQ-029 SHALL, with PWM_FAULT_EN defined, on fault_in = 1 in any state, enter FAULT and set duty_out = 0 on the next edge, without waiting for tick and without pulsing done.
REQ-030 SHALL, with PWM_FAULT_EN defined, give fault_in priority over a simultaneous command accept or tick update.
REQ-031 SHALL, with PWM_FAULT_EN defined, in FAULT drive fault = 1 and cmd_ready = 0, and leave FAULT for IDLE only when fault_clr = 1 and fault_in = 0.
REQ-032 SHALL, without PWM_FAULT_EN defined, have none of the fault ports and no FAULT state.

Structure
REQ-033 SHALL place the state enumeration and the default DUTY_W and TICK_DIV constants in shared package pwm_pkg.
REQ-034 SHALL implement the tick counter as sub-module pwm_tick_gen (params TICK_DIV; ports clk, rst, tick).

Verification
REQ-035 SHALL cover: reset, then cmd_duty = 128 with cmd_ramp = 0 -> duty_out = 128 on the first tick, done pulses once, cmd_ready returns to 1.
REQ-036 SHALL cover: from 0, cmd_duty = 5 with cmd_ramp = 1 and STEP = 2 -> duty_out goes 2, 4, 5 on successive ticks, done on the tick that sets 5.
REQ-037 SHALL cover: from 250, cmd_duty = 255 with ramp and STEP = 4 -> 254 then 255, with no wrap to low values.
REQ-038 SHALL cover: cmd_valid held high during RAMP with a different duty -> the command is ignored and the original target is reached.
REQ-039 SHALL cover: rst asserted mid-ramp at duty_out = 60 -> duty_out = 0 immediately, no done pulse.
REQ-040 SHALL cover, with PWM_FAULT_EN: fault_in mid-ramp -> duty_out = 0 next cycle, fault = 1; fault_clr with fault_in = 0 -> IDLE, cmd_ready = 1.
